// File: rtl/mask_index_pkg.sv
// Shared types and helpers for the mask index stage: result record, skid-buffer states, LSB encoder.
package mask_index_pkg;

    localparam int MASK_W = 8;
    localparam int IDX_W  = $clog2(MASK_W);

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic              zero;
        logic              multi;
        logic [MASK_W-1:0] mask;
    } mask_result_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    // Lowest set bit wins; an all-zero mask encodes to 0.
    function automatic logic [IDX_W-1:0] lsb_index(input logic [MASK_W-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mask_index_skid.sv
// Generic registered 2-entry skid buffer; outputs come from the main register only.
module mask_index_skid
    import mask_index_pkg::*;
#(
    parameter type T = mask_result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    buf_state_e state;
    T           skid;
    logic       in_xfer;
    logic       out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // in_ready and out_valid are registered alongside the state so neither depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_data <= in_data;
                    end else if (in_xfer) begin
                        skid     <= in_data;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        out_data <= skid;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mask_index_stage.sv
// Encodes isolated-bit masks to index/zero/multi and buffers them through a 2-entry skid.
// Optional statistics counters are enabled with `define MASK_INDEX_STATS_EN.
module mask_index_stage
    import mask_index_pkg::*;
#(
    parameter int W  = MASK_W,
    parameter int IW = $clog2(W),
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_mask,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_index,
    output logic          out_zero,
    output logic          out_multi,
    output logic [W-1:0]  out_mask
`ifdef MASK_INDEX_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [CW-1:0] stat_words,
    output logic [CW-1:0] stat_zero,
    output logic [CW-1:0] stat_multi
`endif
);

    mask_result_t enc;
    mask_result_t res;

    always_comb begin
        enc       = '0;
        enc.mask  = in_mask;
        enc.index = lsb_index(in_mask);
        enc.zero  = (in_mask == '0);
        // Clearing the lowest set bit leaves something only if two or more were set.
        enc.multi = ((in_mask & (in_mask - W'(1))) != '0);
    end

    mask_index_skid #(.T(mask_result_t)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (enc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (res)
    );

    assign out_index = res.index;
    assign out_zero  = res.zero;
    assign out_multi = res.multi;
    assign out_mask  = res.mask;

`ifdef MASK_INDEX_STATS_EN
    logic out_xfer;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words <= '0;
            stat_zero  <= '0;
            stat_multi <= '0;
        end else if (stat_clr) begin
            stat_words <= '0;
            stat_zero  <= '0;
            stat_multi <= '0;
        end else if (out_xfer) begin
            if (stat_words != '1)              stat_words <= stat_words + CW'(1);
            if (res.zero && stat_zero != '1)   stat_zero  <= stat_zero + CW'(1);
            if (res.multi && stat_multi != '1) stat_multi <= stat_multi + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mask_index_stage.sv
// Directed self-checking bench for mask_index_stage (stats section active with MASK_INDEX_STATS_EN).
module tb_mask_index_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_mask;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_index;
    logic       out_zero;
    logic       out_multi;
    logic [7:0] out_mask;
`ifdef MASK_INDEX_STATS_EN
    logic       stat_clr;
    logic [3:0] stat_words;
    logic [3:0] stat_zero;
    logic [3:0] stat_multi;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef MASK_INDEX_STATS_EN
    mask_index_stage #(.CW(4)) dut (
`else
    mask_index_stage dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_zero  (out_zero),
        .out_multi (out_multi),
        .out_mask  (out_mask)
`ifdef MASK_INDEX_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_words (stat_words),
        .stat_zero  (stat_zero),
        .stat_multi (stat_multi)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] m);
        in_valid = 1'b1;
        in_mask  = m;
        tick();
    endtask

    task automatic check_out(input string tag, input logic [2:0] idx, input logic z,
                             input logic mu, input logic [7:0] m);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".index"}, 32'(out_index), 32'(idx));
        check({tag, ".zero"},  32'(out_zero),  32'(z));
        check({tag, ".multi"}, 32'(out_multi), 32'(mu));
        check({tag, ".mask"},  32'(out_mask),  32'(m));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;
`ifdef MASK_INDEX_STATS_EN
        stat_clr  = 1'b0;
`endif
        #23;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_index", 32'(out_index), 32'd0);
        check("rst.out_mask",  32'(out_mask),  32'd0);
        rst = 1'b0;
        tick();

        // basic encodes, one per cycle with out_ready high
        out_ready = 1'b1;
        push(8'b0000_0100);
        check_out("enc04", 3'd2, 1'b0, 1'b0, 8'h04);
        push(8'h00);
        check_out("enc00", 3'd0, 1'b1, 1'b0, 8'h00);
        push(8'b0010_1000);
        check_out("enc28", 3'd3, 1'b0, 1'b1, 8'h28);
        push(8'hFF);
        check_out("encFF", 3'd0, 1'b0, 1'b1, 8'hFF);
        in_valid = 1'b0;
        tick();
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // fill to TWO with consumer stalled, then drain in order
        out_ready = 1'b0;
        push(8'h01);
        check("one.in_ready", 32'(in_ready), 32'd1);
        push(8'h80);
        in_valid = 1'b0;
        check("two.in_ready", 32'(in_ready), 32'd0);
        check_out("two.first", 3'd0, 1'b0, 1'b0, 8'h01);
        tick();
        check_out("two.hold", 3'd0, 1'b0, 1'b0, 8'h01);
        out_ready = 1'b1;
        tick();
        check_out("two.second", 3'd7, 1'b0, 1'b0, 8'h80);
        check("two.in_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("two.empty", 32'(out_valid), 32'd0);

        // back-to-back stream, no stall
        for (int i = 0; i < 8; i++) begin
            push(8'(1 << i));
            check_out($sformatf("stream%0d", i), 3'(i), 1'b0, 1'b0, 8'(1 << i));
            check($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream.empty", 32'(out_valid), 32'd0);

        // async reset while holding two words
        out_ready = 1'b0;
        push(8'h10);
        push(8'h20);
        in_valid = 1'b0;
        check("prerst.in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready",  32'(in_ready),  32'd1);
        check("arst.out_mask",  32'(out_mask),  32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("postrst.out_valid", 32'(out_valid), 32'd0);

`ifdef MASK_INDEX_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        push(8'h01);
        push(8'h02);
        push(8'h00);
        push(8'h04);
        push(8'h00);
        push(8'h03);
        in_valid = 1'b0;
        tick();
        check("stat.words", 32'(stat_words), 32'd6);
        check("stat.zero",  32'(stat_zero),  32'd2);
        check("stat.multi", 32'(stat_multi), 32'd1);
        // clear wins over a same-cycle increment
        push(8'h00);
        in_valid = 1'b0;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clr.words", 32'(stat_words), 32'd0);
        check("clr.zero",  32'(stat_zero),  32'd0);
        check("clr.multi", 32'(stat_multi), 32'd0);
        for (int i = 0; i < 20; i++) push(8'h00);
        in_valid = 1'b0;
        tick();
        check("sat.words", 32'(stat_words), 32'd15);
        check("sat.zero",  32'(stat_zero),  32'd15);
        check("sat.multi", 32'(stat_multi), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
